rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL use parameters: N_REGS, default 16, number of architectural registers; ID_W, default 5, register-index width; WORD_W, default 32, data width.
REQ-002 SHALL have ports: clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-004 SHALL have ports: ex_valid, ex_rd[ID_W], ex_wdata[WORD_W]  in  ALU writeback request.
REQ-005 SHALL have ports: ex_ready  out  1  ALU request granted this cycle.
REQ-006 SHALL have ports: ld_valid, ld_rd[ID_W], ld_wdata[WORD_W]  in  load writeback request.
REQ-007 SHALL have ports: ld_ready  out  1  load request granted this cycle.
REQ-008 SHALL have ports: issue_valid, issue_is_load  in  1 each; issue_rd  in  ID_W  destination of instruction issuing this cycle.
REQ-009 SHALL have ports: rs1, rs2  in  ID_W  source indices of the issuing instruction.
REQ-010 SHALL have ports: hazard  out  1  issuing instruction must stall.
REQ-011 SHALL have ports: rf_wen  out  1; rf_rd  out  ID_W; rf_wdata  out  WORD_W  register-file write port.
REQ-012 SHALL have ports: busy  out  N_REGS  pending-load scoreboard.

Function
REQ-013 SHALL arbitrate the single register-file write port between ex and ld using round-robin; last_grant register (0=ex, 1=ld).
REQ-014 SHALL, only ex_valid: grant ex; only ld_valid: grant ld; both: grant side opposite last_grant; neither: no grant, last_grant unchanged.
REQ-015 SHALL drive ex_ready/ld_ready combinationally, at most one high per cycle, never high without matching valid.
REQ-016 SHALL treat a request as consumed in the cycle valid&&ready; an ungranted requester holds valid, rd, wdata stable until granted.
REQ-017 SHALL register the granted rd/wdata into rf_rd/rf_wdata; rf_wen high exactly one cycle after the grant (latency 1).
REQ-018 SHALL drive rf_wen low, rf_rd/rf_wdata holding prior values, in cycles following no grant.
REQ-019 SHALL grant requests with rd==0 or rd>=N_REGS normally but keep rf_wen low for them.
REQ-020 SHALL set busy[issue_rd] on issue_valid && issue_is_load && !hazard && 0<issue_rd<N_REGS.
REQ-021 SHALL clear busy[ld_rd] on ld grant; ex grants never modify busy.
REQ-022 SHALL, on same-cycle set and clear of the same index, leave the bit set.
REQ-023 SHALL compute hazard = issue_valid && (busy[rs1] || busy[rs2] || busy[issue_rd]) combinationally; indices 0 or >=N_REGS never hazard; busy[0] always 0.
REQ-024 SHALL not bypass: a register whose load is granted this cycle still reports hazard this cycle (busy cleared next cycle).
REQ-025 SHALL ignore issue_is_load when issue_valid low.

Reset
REQ-026 SHALL, while reset high at a rising edge: busy=0, rf_wen=0, rf_rd=0, rf_wdata=0, last_grant=1 (ex wins first contention).
REQ-027 SHALL give reset priority over all same-cycle grants and issues; requests granted in the reset cycle are dropped, no rf_wen afterwards.
REQ-028 SHALL drive ex_ready=ld_ready=0 while reset high.

Verification
REQ-029 Bench SHALL cover: ex_valid, ex_rd=5, ex_wdata=0xDEADBEEF alone -> ex_ready same cycle; next cycle rf_wen=1, rf_rd=5, rf_wdata=0xDEADBEEF.
REQ-030 Bench SHALL cover: ex and ld both valid for 4 cycles after reset -> grants ex,ld,ex,ld; rf_wen high 4 consecutive cycles.
REQ-031 Bench SHALL cover: issue load rd=7; next cycle issue with rs1=7 -> hazard=1, busy[7]=1; ld grant rd=7 -> busy[7]=0 following cycle, hazard drops.
REQ-032 Bench SHALL cover: ex write rd=0 wdata=0x1234 -> ex_ready=1, rf_wen stays 0; issue load rd=0 -> busy stays 0.
REQ-033 Bench SHALL cover: ld grant rd=3 and issue load rd=3 same cycle (busy[3] previously set, rs1=rs2=0) -> hazard=1 so no new set; busy[3]=0 next cycle.
REQ-034 Bench SHALL cover: reset asserted with both valid and busy=0x00F0 -> no ready, busy=0 and rf_wen=0 next cycle.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port shared by ALU and
// load writebacks, with a pending-load scoreboard that raises issue hazards.
module rf_wb_arbiter #(
    parameter int N_REGS = 16,
    parameter int ID_W   = 5,
    parameter int WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [ID_W-1:0]   ex_rd,
    input  logic [WORD_W-1:0] ex_wdata,
    output logic              ex_ready,
    input  logic              ld_valid,
    input  logic [ID_W-1:0]   ld_rd,
    input  logic [WORD_W-1:0] ld_wdata,
    output logic              ld_ready,
    input  logic              issue_valid,
    input  logic              issue_is_load,
    input  logic [ID_W-1:0]   issue_rd,
    input  logic [ID_W-1:0]   rs1,
    input  logic [ID_W-1:0]   rs2,
    output logic              hazard,
    output logic              rf_wen,
    output logic [ID_W-1:0]   rf_rd,
    output logic [WORD_W-1:0] rf_wdata,
    output logic [N_REGS-1:0] busy
);

    typedef enum logic {
        GRANT_EX = 1'b0,
        GRANT_LD = 1'b1
    } grant_e;

    localparam logic [ID_W:0] N_REGS_X = (ID_W+1)'(N_REGS);

    grant_e              r_last_grant;
    logic [N_REGS-1:0]   r_busy;
    logic                r_rf_wen;
    logic [ID_W-1:0]     r_rf_rd;
    logic [WORD_W-1:0]   r_rf_wdata;

    logic                w_ex_gnt;
    logic                w_ld_gnt;
    logic                w_set_busy;
    logic [N_REGS-1:0]   w_busy_nxt;
    logic [ID_W-1:0]     w_gnt_rd;
    logic [WORD_W-1:0]   w_gnt_wdata;

    // Index 0 is hardwired and indices past the register file do not exist.
    function automatic logic is_writable(input logic [ID_W-1:0] idx);
        return (idx != '0) && ({1'b0, idx} < N_REGS_X);
    endfunction

    function automatic logic busy_lookup(input logic [N_REGS-1:0] vec,
                                         input logic [ID_W-1:0]   idx);
        logic hit;
        hit = 1'b0;
        for (int i = 1; i < N_REGS; i++) begin
            if (idx == ID_W'(i)) hit = vec[i];
        end
        return hit;
    endfunction

    // On contention the side that did not win last time gets the port.
    assign w_ex_gnt = !reset && ex_valid && (!ld_valid || r_last_grant == GRANT_LD);
    assign w_ld_gnt = !reset && ld_valid && (!ex_valid || r_last_grant == GRANT_EX);
    assign ex_ready = w_ex_gnt;
    assign ld_ready = w_ld_gnt;

    assign w_gnt_rd    = w_ld_gnt ? ld_rd    : ex_rd;
    assign w_gnt_wdata = w_ld_gnt ? ld_wdata : ex_wdata;

    // No bypass: hazard looks at the registered scoreboard only.
    assign hazard = issue_valid && (busy_lookup(r_busy, rs1) ||
                                    busy_lookup(r_busy, rs2) ||
                                    busy_lookup(r_busy, issue_rd));

    assign w_set_busy = issue_valid && issue_is_load && !hazard && is_writable(issue_rd);

    // NOTE: the next value is seeded with the current one before any branch, so no
    // path leaves a bit unassigned and no latch is inferred.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < N_REGS; i++) begin
            if (w_ld_gnt && ld_rd == ID_W'(i))        w_busy_nxt[i] = 1'b0;
            if (w_set_busy && issue_rd == ID_W'(i))   w_busy_nxt[i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= GRANT_LD;
            r_busy       <= '0;
            r_rf_wen     <= 1'b0;
            r_rf_rd      <= '0;
            r_rf_wdata   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_ex_gnt || w_ld_gnt) begin
                r_last_grant <= w_ld_gnt ? GRANT_LD : GRANT_EX;
                r_rf_rd      <= w_gnt_rd;
                r_rf_wdata   <= w_gnt_wdata;
                r_rf_wen     <= is_writable(w_gnt_rd);
            end else begin
                r_rf_wen <= 1'b0;
            end
        end
    end

    assign rf_wen   = r_rf_wen;
    assign rf_rd    = r_rf_rd;
    assign rf_wdata = r_rf_wdata;
    assign busy     = r_busy;

endmodule
